// File: rtl/id_stage_pipe.sv
// RV32 decode stage: field decode, immediate generation, bypassed register file
// read, load-use bubble insertion and the flow-controlled ID/EX pipeline register.

package id_stage_pkg;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  function automatic imm_type_e imm_type_of(input logic [6:0] op);
    case (op)
      OP_LOAD, OP_IMM, OP_JALR: return IMM_I;
      OP_STORE:                 return IMM_S;
      OP_BRANCH:                return IMM_B;
      OP_LUI, OP_AUIPC:         return IMM_U;
      OP_JAL:                   return IMM_J;
      default:                  return IMM_NONE;
    endcase
  endfunction

  function automatic logic uses_rs1(input logic [6:0] op);
    return !(op inside {OP_LUI, OP_AUIPC, OP_JAL});
  endfunction

  function automatic logic uses_rs2(input logic [6:0] op);
    return op inside {OP_REG, OP_STORE, OP_BRANCH};
  endfunction

endpackage

module id_stage_pipe
  import id_stage_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int NREG = 32,
  parameter int PC_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  input  logic [31:0]     if_inst,
  input  logic [PC_W-1:0] if_pc,
  output logic            id_ready,
  input  logic            ex_ready,
  input  logic            flush,
  input  logic            wb_we,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_wd,
  output logic            idex_valid,
  output logic [PC_W-1:0] idex_pc,
  output logic [XLEN-1:0] idex_rd1,
  output logic [XLEN-1:0] idex_rd2,
  output logic [XLEN-1:0] idex_imm,
  output logic [4:0]      idex_rs1,
  output logic [4:0]      idex_rs2,
  output logic [4:0]      idex_rd,
  output logic [6:0]      idex_opcode,
  output logic [2:0]      idex_funct3,
  output logic [6:0]      idex_funct7,
  output logic            hazard_stall
);

  localparam int AW = $clog2(NREG);

  typedef struct packed {
    logic            valid;
    logic [PC_W-1:0] pc;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic [XLEN-1:0] imm;
    logic [4:0]      rs1;
    logic [4:0]      rs2;
    logic [4:0]      rd;
    logic [6:0]      opcode;
    logic [2:0]      funct3;
    logic [6:0]      funct7;
  } idex_t;

  logic [6:0]      opcode;
  logic [4:0]      rd;
  logic [4:0]      rs1;
  logic [4:0]      rs2;
  logic [2:0]      funct3;
  logic [6:0]      funct7;
  imm_type_e       imm_type;
  logic [XLEN-1:0] imm;
  logic [XLEN-1:0] rd1;
  logic [XLEN-1:0] rd2;
  logic            hold;
  idex_t           idex_q;
  idex_t           idex_d;

  assign opcode   = if_inst[6:0];
  assign rd       = if_inst[11:7];
  assign funct3   = if_inst[14:12];
  assign rs1      = if_inst[19:15];
  assign rs2      = if_inst[24:20];
  assign funct7   = if_inst[31:25];
  assign imm_type = imm_type_of(opcode);

  // Each immediate is assembled at its natural width and sign-extended by the cast.
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    imm = '0;
    case (imm_type)
      IMM_I:   imm = XLEN'($signed(if_inst[31:20]));
      IMM_S:   imm = XLEN'($signed({if_inst[31:25], if_inst[11:7]}));
      IMM_B:   imm = XLEN'($signed({if_inst[31], if_inst[7], if_inst[30:25],
                                    if_inst[11:8], 1'b0}));
      IMM_U:   imm = XLEN'($signed({if_inst[31:12], 12'b0}));
      IMM_J:   imm = XLEN'($signed({if_inst[31], if_inst[19:12], if_inst[20],
                                    if_inst[30:21], 1'b0}));
      default: imm = '0;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Register file. x0 and indices beyond NREG are hard-wired to zero.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0] regs [NREG];

  function automatic logic idx_ok(input logic [4:0] idx);
    return (idx != 5'd0) && (32'(idx) < NREG);
  endfunction

  // NOTE: the register array is deliberately left out of reset; only pipeline
  // state is cleared, so the array maps onto plain storage without a reset net.
  always_ff @(posedge clk) begin
    if (wb_we && idx_ok(wb_rd)) regs[wb_rd[AW-1:0]] <= wb_wd;
  end

  // Write-first bypass lets a write-back and a dependent decode share a cycle.
  always_comb begin
    rd1 = '0;
    if (idx_ok(rs1)) begin
      if (wb_we && wb_rd == rs1) rd1 = wb_wd;
      else                       rd1 = regs[rs1[AW-1:0]];
    end
  end

  always_comb begin
    rd2 = '0;
    if (idx_ok(rs2)) begin
      if (wb_we && wb_rd == rs2) rd2 = wb_wd;
      else                       rd2 = regs[rs2[AW-1:0]];
    end
  end

  // ---------------------------------------------------------------------------
  // Hazard detection and flow control
  // ---------------------------------------------------------------------------
  // A load still in ID/EX cannot forward its data to the instruction behind it.
  assign hazard_stall = idex_q.valid && (idex_q.opcode == OP_LOAD) &&
                        (idex_q.rd != 5'd0) && if_valid &&
                        ((uses_rs1(opcode) && rs1 == idex_q.rd) ||
                         (uses_rs2(opcode) && rs2 == idex_q.rd));

  assign hold     = idex_q.valid && !ex_ready;
  assign id_ready = !hold && !hazard_stall && !flush;

  always_comb begin
    idex_d        = '0;
    idex_d.valid  = 1'b1;
    idex_d.pc     = if_pc;
    idex_d.rd1    = rd1;
    idex_d.rd2    = rd2;
    idex_d.imm    = imm;
    idex_d.rs1    = rs1;
    idex_d.rs2    = rs2;
    idex_d.rd     = rd;
    idex_d.opcode = opcode;
    idex_d.funct3 = funct3;
    idex_d.funct7 = funct7;
  end

  // ---------------------------------------------------------------------------
  // ID/EX register. Flush beats hold so a redirect kills a stalled entry.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q <= '0;
    end else if (flush) begin
      idex_q.valid <= 1'b0;
    end else if (hold) begin
      idex_q <= idex_q;
    end else if (hazard_stall) begin
      idex_q.valid <= 1'b0;
    end else if (if_valid) begin
      idex_q <= idex_d;
    end else begin
      idex_q.valid <= 1'b0;
    end
  end

  assign idex_valid  = idex_q.valid;
  assign idex_pc     = idex_q.pc;
  assign idex_rd1    = idex_q.rd1;
  assign idex_rd2    = idex_q.rd2;
  assign idex_imm    = idex_q.imm;
  assign idex_rs1    = idex_q.rs1;
  assign idex_rs2    = idex_q.rs2;
  assign idex_rd     = idex_q.rd;
  assign idex_opcode = idex_q.opcode;
  assign idex_funct3 = idex_q.funct3;
  assign idex_funct7 = idex_q.funct7;

endmodule
